// File: rtl/cache_line_mem_responder.sv
// Memory-side responder for the cache miss path: serves line fills as read bursts
// and absorbs line writebacks as write bursts against an internal word RAM.
module cache_line_mem_responder #(
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned ADDRESS_WIDTH         = 32,
  parameter int unsigned ENTRIES_PER_CACHELINE = 4,
  parameter int unsigned MEM_DEPTH_WORDS       = 1024,
  parameter int unsigned READ_LATENCY          = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic                     wdata_valid,
  output logic                     wdata_ready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic                     rdata_valid,
  input  logic                     rdata_ready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rdata_last,
  output logic                     wr_done
);

  localparam int unsigned BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W      = $clog2(MEM_DEPTH_WORDS);
  localparam int unsigned CNT_W      = $clog2(ENTRIES_PER_CACHELINE);
  localparam int unsigned LINE_W     = IDX_W - CNT_W;
  localparam int unsigned LAT_W      = $clog2(READ_LATENCY + 1);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ENTRIES_PER_CACHELINE - 1);
  localparam logic [LAT_W-1:0] LAT_MAX   = LAT_W'(READ_LATENCY);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    WR_COMMIT,
    WR_ACK
  } state_e;

  state_e                  state_q, state_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic                    req_ready_q, req_ready_d;
  logic                    wdata_ready_q, wdata_ready_d;
  logic                    rdata_valid_q, rdata_valid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rdata_last_q, rdata_last_d;
  logic                    wr_done_q, wr_done_d;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH_WORDS];
  logic [CNT_W-1:0]        rd_cnt_c;
  logic [DATA_WIDTH-1:0]   rd_word_c;
  logic                    mem_we_c;
  logic [IDX_W-1:0]        mem_widx_c;
  logic                    unused_addr_parity;

  // Byte offset and line-offset bits of req_addr are dropped by the line mapping.
  assign unused_addr_parity = ^req_addr;

  // In a burst the next beat is prefetched so beats stream at one per cycle.
  assign rd_cnt_c   = (state_q == RD_BURST) ? cnt_q + 1'b1 : cnt_q;
  assign rd_word_c  = mem_q[{line_q, rd_cnt_c}];
  assign mem_we_c   = (state_q == WR_BURST) && wdata_valid;
  assign mem_widx_c = {line_q, cnt_q};

  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    cnt_d         = cnt_q;
    lat_d         = lat_q;
    req_ready_d   = req_ready_q;
    wdata_ready_d = wdata_ready_q;
    rdata_valid_d = rdata_valid_q;
    rdata_d       = rdata_q;
    rdata_last_d  = rdata_last_q;
    wr_done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          line_d      = req_addr[BYTE_SHIFT + CNT_W +: LINE_W];
          cnt_d       = '0;
          lat_d       = '0;
          if (req_we) begin
            state_d       = WR_BURST;
            wdata_ready_d = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end

      // One extra cycle beyond READ_LATENCY loads beat 0 into the output register.
      RD_WAIT: begin
        if (lat_q == LAT_MAX) begin
          state_d       = RD_BURST;
          rdata_valid_d = 1'b1;
          rdata_d       = rd_word_c;
          rdata_last_d  = (cnt_q == LAST_BEAT);
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      RD_BURST: begin
        if (rdata_ready && rdata_valid_q) begin
          if (cnt_q == LAST_BEAT) begin
            state_d       = IDLE;
            rdata_valid_d = 1'b0;
            rdata_last_d  = 1'b0;
            rdata_d       = '0;
            req_ready_d   = 1'b1;
          end else begin
            cnt_d        = rd_cnt_c;
            rdata_d      = rd_word_c;
            rdata_last_d = (rd_cnt_c == LAST_BEAT);
          end
        end
      end

      WR_BURST: begin
        if (wdata_valid) begin
          if (cnt_q == LAST_BEAT) begin
            state_d       = WR_COMMIT;
            wdata_ready_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Final beat is already in the RAM; acknowledge on the following cycle.
      WR_COMMIT: begin
        state_d   = WR_ACK;
        wr_done_d = 1'b1;
      end

      WR_ACK: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      line_q        <= '0;
      cnt_q         <= '0;
      lat_q         <= '0;
      req_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      rdata_last_q  <= 1'b0;
      wr_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      cnt_q         <= cnt_d;
      lat_q         <= lat_d;
      req_ready_q   <= req_ready_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
      rdata_last_q  <= rdata_last_d;
      wr_done_q     <= wr_done_d;
    end
  end

  // RAM contents survive reset; a write lands on the edge that accepts the beat.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_widx_c] <= wdata;
    end
  end

  assign req_ready   = req_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign rdata_last  = rdata_last_q;
  assign wr_done     = wr_done_q;

endmodule

// File: tb/tb_cache_line_mem_responder.sv
// Directed bench for cache_line_mem_responder: cycle-by-cycle vector tables plus
// hand-written reset sequences, all expectations computed by hand.
module tb_cache_line_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic        rdata_ready;
  logic [31:0] rdata;
  logic        rdata_last;
  logic        wr_done;

  int n_applied = 0;
  int n_miss    = 0;

  typedef struct {
    logic        rv;
    logic        we;
    logic [31:0] addr;
    logic        wv;
    logic [31:0] wd;
    logic        rr;
    logic        e_req_ready;
    logic        e_wdata_ready;
    logic        e_rdata_valid;
    logic [31:0] e_rdata;
    logic        e_rdata_last;
    logic        e_wr_done;
  } vec_t;

  vec_t vecs[$];

  cache_line_mem_responder #(
    .DATA_WIDTH           (32),
    .ADDRESS_WIDTH        (32),
    .ENTRIES_PER_CACHELINE(4),
    .MEM_DEPTH_WORDS      (1024),
    .READ_LATENCY         (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .rdata      (rdata),
    .rdata_last (rdata_last),
    .wr_done    (wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, applied=%0d", n_applied);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic erq, input logic ewr, input logic erv,
                       input logic [31:0] erd, input logic erl, input logic ewd, input bit chk_rd);
    bit bad;
    n_applied++;
    bad = (req_ready !== erq) || (wdata_ready !== ewr) || (rdata_valid !== erv) ||
          (rdata_last !== erl) || (wr_done !== ewd) || (chk_rd && (rdata !== erd));
    if (bad) begin
      n_miss++;
      $display("FAIL %s: got rr=%b wr=%b rv=%b rd=%h rl=%b wd=%b, want rr=%b wr=%b rv=%b rd=%h rl=%b wd=%b",
               nm, req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done,
               erq, ewr, erv, erd, erl, ewd);
    end
  endtask

  task automatic add(input logic rv, input logic we, input logic [31:0] a, input logic wv,
                     input logic [31:0] wd, input logic rr, input logic erq, input logic ewr,
                     input logic erv, input logic [31:0] erd, input logic erl, input logic ewd);
    vec_t v;
    v.rv = rv; v.we = we; v.addr = a; v.wv = wv; v.wd = wd; v.rr = rr;
    v.e_req_ready = erq; v.e_wdata_ready = ewr; v.e_rdata_valid = erv;
    v.e_rdata = erd; v.e_rdata_last = erl; v.e_wr_done = ewd;
    vecs.push_back(v);
  endtask

  // Back-to-back writeback: accept, 4 beats, commit, wr_done, idle.
  task automatic add_wb(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
    add(1, 1, a, 0, 0,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, d0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, d1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, d2, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, d3, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
  endtask

  // Fill without backpressure: beat 0 visible 3 cycles after accept, last at +6.
  task automatic add_fill(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    add(1, 0, a, 0, 0, 1, 0, 0, 0, 0,  0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, d0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, d1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, d2, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, d3, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0);
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      req_valid   = vecs[i].rv;
      req_we      = vecs[i].we;
      req_addr    = vecs[i].addr;
      wdata_valid = vecs[i].wv;
      wdata       = vecs[i].wd;
      rdata_ready = vecs[i].rr;
      tick();
      check($sformatf("%s_vec%0d", tag, i), vecs[i].e_req_ready, vecs[i].e_wdata_ready,
            vecs[i].e_rdata_valid, vecs[i].e_rdata, vecs[i].e_rdata_last, vecs[i].e_wr_done,
            vecs[i].e_rdata_valid);
    end
    vecs.delete();
    req_valid = 0; req_we = 0; req_addr = 0; wdata_valid = 0; wdata = 0; rdata_ready = 0;
  endtask

  initial begin
    reset = 1; req_valid = 0; req_we = 0; req_addr = 0;
    wdata_valid = 0; wdata = 0; rdata_ready = 0;
    tick();
    tick();
    check("reset_held", 0, 0, 0, 32'h0, 0, 0, 1);
    reset = 0;
    tick();
    check("reset_release", 1, 0, 0, 32'h0, 0, 0, 1);

    // Stray write beat while idle is not accepted.
    add(0, 0, 0, 1, 32'hBAD0_0001, 0, 1, 0, 0, 0, 0, 0);
    add_wb(32'h0000_0010, 32'h11, 32'h22, 32'h33, 32'h44);
    add_fill(32'h0000_0010, 32'h11, 32'h22, 32'h33, 32'h44);
    add_fill(32'h0000_0018, 32'h11, 32'h22, 32'h33, 32'h44);
    add_fill(32'h0000_1010, 32'h11, 32'h22, 32'h33, 32'h44);

    // Fill with rdata_ready 1,0,0,1,0,1,1 and a competing request during stalls.
    add(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0,     0, 0);
    add(0, 0, 0,      0, 0, 0, 0, 0, 0, 0,     0, 0);
    add(0, 0, 0,      0, 0, 0, 0, 0, 0, 0,     0, 0);
    add(0, 0, 0,      0, 0, 0, 0, 0, 1, 32'h11, 0, 0);
    add(0, 0, 0,      0, 0, 1, 0, 0, 1, 32'h22, 0, 0);
    add(1, 1, 32'h80, 0, 0, 0, 0, 0, 1, 32'h22, 0, 0);
    add(1, 1, 32'h80, 0, 0, 0, 0, 0, 1, 32'h22, 0, 0);
    add(0, 0, 0,      0, 0, 1, 0, 0, 1, 32'h33, 0, 0);
    add(0, 0, 0,      0, 0, 0, 0, 0, 1, 32'h33, 0, 0);
    add(0, 0, 0,      0, 0, 1, 0, 0, 1, 32'h44, 1, 0);
    add(0, 0, 0,      0, 0, 1, 1, 0, 0, 0,     0, 0);

    // Writeback with wdata_valid 1,0,1,0,1,1 and a fill request held throughout.
    add(1, 1, 32'h20, 0, 0,            0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 32'h10, 1, 32'h55,       0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 32'h10, 0, 32'hDEAD,     0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 32'h10, 1, 32'h66,       0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 32'h10, 0, 32'hBEEF,     0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 32'h10, 1, 32'h77,       0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 32'h10, 1, 32'h88,       0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 32'h10, 0, 0,            0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0,      0, 0,            0, 1, 0, 0, 0, 0, 0);
    add_fill(32'h0000_0020, 32'h55, 32'h66, 32'h77, 32'h88);

    // Known old contents for the line used by the reset-abort case.
    add_wb(32'h0000_0040, 32'h5001, 32'h5002, 32'h5003, 32'h5004);
    run_table("main");

    // Writeback of 0xA..0xD to 0x40 abandoned by reset after two beats.
    req_valid = 1; req_we = 1; req_addr = 32'h40;
    tick();
    req_valid = 0; req_we = 0; req_addr = 0;
    check("abort_accept", 0, 1, 0, 32'h0, 0, 0, 0);
    wdata_valid = 1; wdata = 32'hA;
    tick();
    wdata = 32'hB;
    tick();
    check("abort_beat2", 0, 1, 0, 32'h0, 0, 0, 0);
    wdata = 32'hC;
    #2;
    reset = 1;
    #1;
    check("abort_async", 0, 0, 0, 32'h0, 0, 0, 1);
    tick();
    check("abort_held", 0, 0, 0, 32'h0, 0, 0, 1);
    reset = 0;
    wdata_valid = 0; wdata = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("abort_idle%0d", i), 1, 0, 0, 32'h0, 0, 0, 1);
    end

    add_fill(32'h0000_0040, 32'hA, 32'hB, 32'h5003, 32'h5004);
    run_table("post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/cache_line_mem_responder.md
Name: cache_line_mem_responder

Overview:
- Memory-side responder for the cache's line-fill/writeback bus. Serves line fills (read bursts) and accepts line writebacks (write bursts) on a cache miss.
- Backed by an internal word-addressed RAM.
- Sits under cache_2 in simulation and FPGA builds, as the far end of the miss path.

Parameters:
- DATA_WIDTH, 32, beat/word width in bits.
- ADDRESS_WIDTH, 32, byte address width.
- ENTRIES_PER_CACHELINE, 4, beats per burst; power of 2, >=2.
- MEM_DEPTH_WORDS, 1024, RAM depth in words; power of 2.
- READ_LATENCY, 2, idle cycles between request accept and the first read beat; >=1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  burst request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = writeback burst, 0 = line fill.
- req_addr  in  ADDRESS_WIDTH  byte address of the line.
- wdata_valid  in  1  write beat present.
- wdata_ready  out  1  write beat accepted this cycle.
- wdata  in  DATA_WIDTH  write beat data.
- rdata_valid  out  1  read beat present.
- rdata_ready  in  1  cache accepts read beat.
- rdata  out  DATA_WIDTH  read beat data.
- rdata_last  out  1  final beat of a fill.
- wr_done  out  1  one-cycle pulse when a writeback has completed.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled by the top level):
  - FSM goes to IDLE.
  - req_ready=0 while reset is high, then 1 in IDLE.
  - wdata_ready=0, rdata_valid=0, rdata_last=0, wr_done=0, rdata=0.
  - RAM contents are not cleared.
- Address mapping:
  - base word = (req_addr >> log2(DATA_WIDTH/8)) with the low log2(ENTRIES_PER_CACHELINE) bits forced to 0. Unaligned addresses are aligned down.
  - Word index is taken modulo MEM_DEPTH_WORDS (wraps, no error).
  - Beat k addresses base+k. A burst never crosses a line boundary.
- Handshake: a transfer happens on any cycle with valid&&ready high at the clock edge. Each request is latched on acceptance (addr, we).
- FSM states:
  - IDLE: req_ready=1. Accept goes to RD_WAIT if we=0, or to WR_BURST if we=1. Latch the base index and clear the beat counter.
  - RD_WAIT: count READ_LATENCY cycles, then go to RD_BURST with beat 0 presented.
  - RD_BURST:
    - rdata_valid=1, rdata=RAM[base+cnt], rdata_last=(cnt==ENTRIES_PER_CACHELINE-1).
    - rdata/rdata_last are held stable while rdata_ready=0.
    - On a beat transfer, cnt++. A transfer on the last beat goes to IDLE.
    - Sustained rate is 1 beat/cycle when rdata_ready stays high: beat k+1 is valid in the cycle after beat k is accepted.
  - WR_BURST:
    - wdata_ready=1. Each wdata_valid cycle writes RAM[base+cnt]=wdata and increments cnt.
    - After the last beat, go to WR_ACK.
  - WR_ACK: wr_done=1 for exactly one cycle, then IDLE.
- req_ready is 0 in every state except IDLE; requests are not queued.
- Read-after-write: a fill that immediately follows a writeback to the same line returns the new data. RAM write completes before WR_ACK.
- Unrequested wdata_valid outside WR_BURST is ignored (wdata_ready=0).
- Reset mid-burst: the burst is abandoned. Partially written words stay written, and no wr_done is issued.
- Counter width is log2(ENTRIES_PER_CACHELINE); wrap after the last beat is not reachable because of the state exit.
- Latency (ENTRIES_PER_CACHELINE=4, READ_LATENCY=2, no backpressure):
  - Fill: first beat 3 cycles after the accept edge, last beat at +6, req_ready again at +7.
  - Writeback with back-to-back beats: wr_done 5 cycles after the accept edge.

Test Plan:
- Reset release -> req_ready=1, rdata_valid=0, wr_done=0. Writeback to 0x0000_0010 with beats 0x11,0x22,0x33,0x44 -> wr_done pulses for one cycle, 5 cycles after accept.
- Fill from 0x0000_0010 with rdata_ready=1 -> beats 0x11,0x22,0x33,0x44 on consecutive cycles, first beat 3 cycles after accept, rdata_last only on 0x44.
- Fill from 0x0000_0018 (unaligned) -> same 4 beats starting 0x11. Fill from 0x0000_1010 with MEM_DEPTH_WORDS=1024 -> wraps to word 4, returns 0x11 first.
- Fill with rdata_ready toggling 1,0,0,1,0,1,1 -> no beat lost or duplicated; rdata held stable during stalls; req_ready stays 0 until the last transfer.
- Writeback with wdata_valid gaps (valid 1,0,1,0,1,1) -> exactly 4 words written, wr_done after the 4th beat; a second req_valid during the burst is not accepted.
- Assert reset during beat 2 of a writeback of 0xA..0xD to 0x40 -> outputs go to reset values immediately, no wr_done. A later fill from 0x40 returns 0xA,0xB followed by the old contents.
